control_unit: RTL and testbench
===============================

# control_unit

Hardwired sequencer for the single-bus processor datapath. It steps the fetch cycle (T0–T2), decodes the opcode in IR, and drives the per-step register-transfer strobes that benches otherwise force by hand: PCout, MARin, Zin, Gra/Rin and so on. It sits beside `proc`, reads `IR`, and drives every datapath control line through one packed control word. Run/Stop/halt handling lets the processor execute from memory unattended.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `Stop` input 1: request to halt at the next instruction boundary.
- `IR` input 32: instruction register contents.
  - opcode is IR[31:27].
  - Ra/Rb/Rc select is done in the datapath via Gra/Grb/Grc.
- `ctrl` output 24: control word, bit map below.
- `Run` output 1: high while executing; low in RST and HALT.
- `busy_step` output 4: current step index (0–7), for debug.

## Operation
- ctrl bit map:
  - [0] PCout, [1] PCin, [2] IncPC, [3] MARin, [4] MDRin, [5] MDRout
  - [6] Read, [7] Write, [8] IRin, [9] Yin, [10] Zin, [11] Zlowout
  - [12] Zhighout, [13] HIin, [14] LOin, [15] HIout, [16] LOout, [17] Gra
  - [18] Grb, [19] Grc, [20] Rin, [21] Rout, [22] BAout, [23] Cout
- Moore FSM: the state register updates on clk; ctrl is combinational from state and the latched opcode. Unlisted bits are 0.
- States: RST, T0, T1a, T1b, T2, T3–T7, T6b, HALT.
- The ALU decodes its operation from IR itself; this block supplies only strobes.
- Fetch:
  - T0: PCout MARin IncPC Zin.
  - T1a, T1b: Zlowout PCin Read MDRin. This is a two-cycle memory wait; PCin is asserted in T1b only.
  - T2: MDRout IRin.
- The opcode is captured at the end of T2, i.e. from the IR value loaded in T2.
- Execute by opcode:
  - 00011–01010 (add, sub, shr, shl, ror, rol, and, or):
    - T3: Grb Rout Yin.
    - T4: Grc Rout Zin.
    - T5: Zlowout Gra Rin.
  - 01011–01101 (addi, andi, ori):
    - T3: Grb Rout Yin.
    - T4: Cout Zin.
    - T5: Zlowout Gra Rin.
  - 00001 ldi:
    - T3: Grb BAout Yin.
    - T4: Cout Zin.
    - T5: Zlowout Gra Rin.
  - 00000 ld:
    - T3/T4 as ldi.
    - T5: Zlowout MARin.
    - T6, T6b: Read MDRin.
    - T7: MDRout Gra Rin.
  - 00010 st:
    - T3/T4 as ldi.
    - T5: Zlowout MARin.
    - T6: Gra Rout MDRin (Read low, so MDR takes the bus).
    - T7: Write.
  - 01110 mul, 01111 div:
    - T3: Gra Rout Yin.
    - T4: Grb Rout Zin.
    - T5: Zlowout LOin.
    - T6: Zhighout HIin.
  - 10111 mfhi: T3: Gra Rin HIout.
  - 11000 mflo: T3: Gra Rin LOout.
  - 10011 jr: T3: Gra Rout PCin.
  - 11001 nop and all undefined opcodes: T2 returns directly to T0.
  - 11010 halt: T2 goes to HALT.
- Every instruction's last step goes to T0, or to HALT if a Stop was latched.
- Stop is sampled every cycle into a sticky flag.
  - The flag is consulted only at instruction end.
  - The flag is cleared by reset.
- HALT is terminal: ctrl = 0, Run = 0. Only reset exits it.

## Timing
- Reset:
  - reset high at a rising edge puts the FSM in RST next cycle.
  - In RST: ctrl = 0, Run = 0, busy_step = 0, Stop flag cleared, latched opcode = 0.
  - reset overrides any state, including mid-instruction and HALT.
  - RST goes to T0 on the first edge with reset low. Run = 1 from T0 onward.
- Cycle counts, T0 through last step inclusive:
  - nop: 4
  - mfhi, mflo, jr: 5
  - ALU, imm, ldi: 7
  - mul, div: 8
  - st: 9
  - ld: 10
- busy_step:
  - 0 in T0; 1 in T1a and T1b; 2–7 for T2–T7.
  - 6 in T6b.
  - 0 in RST and HALT.
- Stop raised during the final step of an instruction takes effect at that step's transition (no T0 issued).
- Stop raised during T0 lets the whole instruction complete.
- Write is asserted in exactly one cycle per st. Read is asserted in exactly two consecutive cycles per memory access.

## Test plan
- Reset, then addi R2,R1,35 at PC=7 with R1=5 → R2=40 after 7 cycles; PC=8; Rin high only in T5.
- ld R3,4(R0) with mem[4]=0x1234 → Read/MDRin high for exactly 2 cycles in T6/T6b; R3=0x1234 at the 10th cycle; next fetch from PC+1.
- st R2,8(R0) with R2=40 → Write pulses once in cycle 9; mem[8]=40; Read stays low throughout T5–T7.
- mfhi R2 then mflo R2 with HI=100, LO=10 → R2=100 after 5 cycles, then R2=10 after 5 more; HIout and LOout each high exactly one cycle.
- Stop pulsed for one cycle during T4 of an add → add completes, FSM enters HALT; Run=0, ctrl=0; remains halted 20 cycles.
- halt opcode → HALT after T2.
- reset asserted during T6 of a ld → next cycle RST with ctrl=0; following cycle T0 and fetch restarts; no Rin issued for the aborted ld.

Source files
------------

// File: rtl/control_unit_if.sv
// Bundle between the hardwired sequencer and the rest of the single-bus
// processor: instruction in, control word and status out.
interface control_unit_if;
    logic        Stop;       // request to halt at the next instruction boundary
    logic [31:0] IR;         // instruction register contents
    logic [23:0] ctrl;       // packed datapath control word
    logic        Run;        // high while executing
    logic [3:0]  busy_step;  // current step index for debug

    // Datapath / bench side: supplies IR and Stop, observes the strobes.
    modport master (
        output Stop,
        output IR,
        input  ctrl,
        input  Run,
        input  busy_step
    );

    // Sequencer side.
    modport slave (
        input  Stop,
        input  IR,
        output ctrl,
        output Run,
        output busy_step
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the single-bus processor. Steps the fetch
// cycle, decodes the opcode and issues per-step register-transfer strobes.
module control_unit (
    input  logic          clk,
    input  logic          reset,
    control_unit_if.slave bus
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1A, S_T1B, S_T2, S_T3, S_T4,
        S_T5, S_T6, S_T6B, S_T7, S_HALT
    } state_e;

    // Instructions grouped by the shape of their execute sequence.
    typedef enum logic [3:0] {
        C_NOP, C_HALT, C_LD, C_LDI, C_ST, C_ALU, C_IMM,
        C_MULDIV, C_MFHI, C_MFLO, C_JR
    } op_class_e;

    // Bit positions inside the control word.
    localparam int PCOUT   = 0;
    localparam int PCIN    = 1;
    localparam int INCPC   = 2;
    localparam int MARIN   = 3;
    localparam int MDRIN   = 4;
    localparam int MDROUT  = 5;
    localparam int READ    = 6;
    localparam int WRITE   = 7;
    localparam int IRIN    = 8;
    localparam int YIN     = 9;
    localparam int ZIN     = 10;
    localparam int ZLOWOUT = 11;
    localparam int ZHIOUT  = 12;
    localparam int HIIN    = 13;
    localparam int LOIN    = 14;
    localparam int HIOUT   = 15;
    localparam int LOOUT   = 16;
    localparam int GRA     = 17;
    localparam int GRB     = 18;
    localparam int GRC     = 19;
    localparam int RIN     = 20;
    localparam int ROUT    = 21;
    localparam int BAOUT   = 22;
    localparam int COUT    = 23;

    function automatic op_class_e decode_op(input logic [4:0] op);
        op_class_e cls;
        case (op)
            5'd0:                   cls = C_LD;
            5'd1:                   cls = C_LDI;
            5'd2:                   cls = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6,
            5'd7, 5'd8, 5'd9, 5'd10: cls = C_ALU;
            5'd11, 5'd12, 5'd13:    cls = C_IMM;
            5'd14, 5'd15:           cls = C_MULDIV;
            5'd19:                  cls = C_JR;
            5'd23:                  cls = C_MFHI;
            5'd24:                  cls = C_MFLO;
            5'd26:                  cls = C_HALT;
            default:                cls = C_NOP;  // nop and undefined opcodes
        endcase
        return cls;
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  opcode_q, opcode_d;
    logic        stop_q, stop_d;
    logic [23:0] ctrl_w;
    logic [3:0]  step_w;
    logic        run_w;
    op_class_e   ir_class, op_class;
    state_e      end_state;

    // Register fields are routed by Gra/Grb/Grc in the datapath, not here.
    logic ir_unused;
    assign ir_unused = ^bus.IR[26:0];

    // State, latched opcode and sticky stop flag; reset wins over everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RST;
            opcode_q <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            stop_q   <= stop_d;
        end
    end

    // Opcode capture at the end of T2 and Stop accumulation.
    always_comb begin
        ir_class  = decode_op(bus.IR[31:27]);
        op_class  = decode_op(opcode_q);
        opcode_d  = (state_q == S_T2) ? bus.IR[31:27] : opcode_q;
        // A Stop arriving in the final step still counts at that step's edge.
        stop_d    = stop_q | bus.Stop;
        end_state = stop_d ? S_HALT : S_T0;
    end

    // Next-state and control-word decode.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ctrl_w  = '0;
        step_w  = 4'd0;
        run_w   = 1'b1;
        unique case (state_q)
            S_RST: begin
                run_w   = 1'b0;
                state_d = S_T0;
            end
            S_T0: begin
                ctrl_w[PCOUT] = 1'b1;
                ctrl_w[MARIN] = 1'b1;
                ctrl_w[INCPC] = 1'b1;
                ctrl_w[ZIN]   = 1'b1;
                state_d       = S_T1A;
            end
            S_T1A, S_T1B: begin
                step_w          = 4'd1;
                ctrl_w[ZLOWOUT] = 1'b1;
                ctrl_w[READ]    = 1'b1;
                ctrl_w[MDRIN]   = 1'b1;
                // PC is loaded only once the memory wait is over.
                ctrl_w[PCIN]    = (state_q == S_T1B);
                state_d         = (state_q == S_T1A) ? S_T1B : S_T2;
            end
            S_T2: begin
                step_w         = 4'd2;
                ctrl_w[MDROUT] = 1'b1;
                ctrl_w[IRIN]   = 1'b1;
                case (ir_class)
                    C_HALT:  state_d = S_HALT;
                    C_NOP:   state_d = end_state;
                    default: state_d = S_T3;
                endcase
            end
            S_T3: begin
                step_w  = 4'd3;
                state_d = S_T4;
                case (op_class)
                    C_ALU, C_IMM: begin
                        ctrl_w[GRB] = 1'b1; ctrl_w[ROUT] = 1'b1; ctrl_w[YIN] = 1'b1;
                    end
                    C_LDI, C_LD, C_ST: begin
                        ctrl_w[GRB] = 1'b1; ctrl_w[BAOUT] = 1'b1; ctrl_w[YIN] = 1'b1;
                    end
                    C_MULDIV: begin
                        ctrl_w[GRA] = 1'b1; ctrl_w[ROUT] = 1'b1; ctrl_w[YIN] = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl_w[GRA] = 1'b1; ctrl_w[RIN] = 1'b1; ctrl_w[HIOUT] = 1'b1;
                        state_d = end_state;
                    end
                    C_MFLO: begin
                        ctrl_w[GRA] = 1'b1; ctrl_w[RIN] = 1'b1; ctrl_w[LOOUT] = 1'b1;
                        state_d = end_state;
                    end
                    C_JR: begin
                        ctrl_w[GRA] = 1'b1; ctrl_w[ROUT] = 1'b1; ctrl_w[PCIN] = 1'b1;
                        state_d = end_state;
                    end
                    default: state_d = end_state;
                endcase
            end
            S_T4: begin
                step_w      = 4'd4;
                state_d     = S_T5;
                ctrl_w[ZIN] = 1'b1;
                case (op_class)
                    C_ALU:    begin ctrl_w[GRC] = 1'b1; ctrl_w[ROUT] = 1'b1; end
                    C_MULDIV: begin ctrl_w[GRB] = 1'b1; ctrl_w[ROUT] = 1'b1; end
                    default:  ctrl_w[COUT] = 1'b1;
                endcase
            end
            S_T5: begin
                step_w          = 4'd5;
                ctrl_w[ZLOWOUT] = 1'b1;
                case (op_class)
                    C_LD, C_ST: begin ctrl_w[MARIN] = 1'b1; state_d = S_T6; end
                    C_MULDIV:   begin ctrl_w[LOIN]  = 1'b1; state_d = S_T6; end
                    default: begin
                        ctrl_w[GRA] = 1'b1; ctrl_w[RIN] = 1'b1;
                        state_d = end_state;
                    end
                endcase
            end
            S_T6: begin
                step_w = 4'd6;
                case (op_class)
                    C_LD: begin
                        ctrl_w[READ] = 1'b1; ctrl_w[MDRIN] = 1'b1;
                        state_d = S_T6B;
                    end
                    C_ST: begin
                        // Read stays low so MDR loads from the bus.
                        ctrl_w[GRA] = 1'b1; ctrl_w[ROUT] = 1'b1; ctrl_w[MDRIN] = 1'b1;
                        state_d = S_T7;
                    end
                    default: begin
                        ctrl_w[ZHIOUT] = 1'b1; ctrl_w[HIIN] = 1'b1;
                        state_d = end_state;
                    end
                endcase
            end
            S_T6B: begin
                step_w        = 4'd6;
                ctrl_w[READ]  = 1'b1;
                ctrl_w[MDRIN] = 1'b1;
                state_d       = S_T7;
            end
            S_T7: begin
                step_w  = 4'd7;
                state_d = end_state;
                if (op_class == C_ST) begin
                    ctrl_w[WRITE] = 1'b1;
                end else begin
                    ctrl_w[MDROUT] = 1'b1; ctrl_w[GRA] = 1'b1; ctrl_w[RIN] = 1'b1;
                end
            end
            S_HALT: begin
                run_w   = 1'b0;
                state_d = S_HALT;
            end
            default: begin
                run_w   = 1'b0;
                state_d = S_RST;
            end
        endcase
    end

    assign bus.ctrl      = ctrl_w;
    assign bus.Run       = run_w;
    assign bus.busy_step = step_w;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: checks the control word, step index and
// Run for each instruction class, Stop/halt handling and reset recovery.
module tb_control_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    control_unit_if dut_if();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word bits, written out independently of the design.
    localparam logic [23:0] PCOUT   = 24'h000001;
    localparam logic [23:0] PCIN    = 24'h000002;
    localparam logic [23:0] INCPC   = 24'h000004;
    localparam logic [23:0] MARIN   = 24'h000008;
    localparam logic [23:0] MDRIN   = 24'h000010;
    localparam logic [23:0] MDROUT  = 24'h000020;
    localparam logic [23:0] READ    = 24'h000040;
    localparam logic [23:0] WRITE   = 24'h000080;
    localparam logic [23:0] IRIN    = 24'h000100;
    localparam logic [23:0] YIN     = 24'h000200;
    localparam logic [23:0] ZIN     = 24'h000400;
    localparam logic [23:0] ZLOW    = 24'h000800;
    localparam logic [23:0] ZHIGH   = 24'h001000;
    localparam logic [23:0] HIIN    = 24'h002000;
    localparam logic [23:0] LOIN    = 24'h004000;
    localparam logic [23:0] HIOUT   = 24'h008000;
    localparam logic [23:0] LOOUT   = 24'h010000;
    localparam logic [23:0] GRA     = 24'h020000;
    localparam logic [23:0] GRB     = 24'h040000;
    localparam logic [23:0] GRC     = 24'h080000;
    localparam logic [23:0] RIN     = 24'h100000;
    localparam logic [23:0] ROUT    = 24'h200000;
    localparam logic [23:0] BAOUT   = 24'h400000;
    localparam logic [23:0] COUT    = 24'h800000;

    localparam logic [23:0] W_T0  = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [23:0] W_T1A = ZLOW | READ | MDRIN;
    localparam logic [23:0] W_T1B = ZLOW | READ | MDRIN | PCIN;
    localparam logic [23:0] W_T2  = MDROUT | IRIN;

    // Instruction words: opcode plus arbitrary register/immediate fields.
    localparam logic [31:0] I_ADDI = {5'b01011, 4'd2, 4'd1, 19'd35};
    localparam logic [31:0] I_ADD  = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    localparam logic [31:0] I_LD   = {5'b00000, 4'd3, 4'd0, 19'd4};
    localparam logic [31:0] I_ST   = {5'b00010, 4'd2, 4'd0, 19'd8};
    localparam logic [31:0] I_MUL  = {5'b01110, 4'd4, 4'd5, 19'd0};
    localparam logic [31:0] I_MFHI = {5'b10111, 4'd2, 23'd0};
    localparam logic [31:0] I_MFLO = {5'b11000, 4'd2, 23'd0};
    localparam logic [31:0] I_JR   = {5'b10011, 4'd6, 23'd0};
    localparam logic [31:0] I_NOP  = {5'b11001, 27'd0};
    localparam logic [31:0] I_UNDF = {5'b11111, 27'h5a5a5a5};
    localparam logic [31:0] I_HALT = {5'b11010, 27'd0};

    logic [23:0] exp_ctrl [16];
    logic [3:0]  exp_step [16];
    logic [23:0] obs_ctrl [16];
    logic [3:0]  obs_step [16];
    logic        obs_run  [16];

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Expected fetch prefix shared by every instruction.
    task automatic set_fetch();
        exp_ctrl[0] = W_T0;  exp_step[0] = 4'd0;
        exp_ctrl[1] = W_T1A; exp_step[1] = 4'd1;
        exp_ctrl[2] = W_T1B; exp_step[2] = 4'd1;
        exp_ctrl[3] = W_T2;  exp_step[3] = 4'd2;
    endtask

    // Record n consecutive cycles of outputs, starting at the current cycle.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            obs_ctrl[i] = dut_if.ctrl;
            obs_step[i] = dut_if.busy_step;
            obs_run[i]  = dut_if.Run;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dut_if.Stop = 1'b0;
        dut_if.IR = I_NOP;
        tick();
        tick();
        total++; if (dut_if.ctrl !== 24'h0) begin bad++; $display("FAIL rst_ctrl got=%h want=000000", dut_if.ctrl); end
        total++; if (dut_if.Run !== 1'b0) begin bad++; $display("FAIL rst_run got=%b want=0", dut_if.Run); end
        total++; if (dut_if.busy_step !== 4'd0) begin bad++; $display("FAIL rst_step got=%0d want=0", dut_if.busy_step); end
        reset = 1'b0;
        tick();
        total++; if (dut_if.ctrl !== W_T0) begin bad++; $display("FAIL rst_t0_ctrl got=%h want=%h", dut_if.ctrl, W_T0); end
        total++; if (dut_if.Run !== 1'b1) begin bad++; $display("FAIL rst_t0_run got=%b want=1", dut_if.Run); end
    endtask

    task automatic test_addi();
        dut_if.IR = I_ADDI;
        set_fetch();
        exp_ctrl[4] = GRB | ROUT | YIN;  exp_step[4] = 4'd3;
        exp_ctrl[5] = COUT | ZIN;        exp_step[5] = 4'd4;
        exp_ctrl[6] = ZLOW | GRA | RIN;  exp_step[6] = 4'd5;
        capture(7);
        for (int i = 0; i < 7; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i]) begin bad++; $display("FAIL addi_ctrl c%0d got=%h want=%h", i, obs_ctrl[i], exp_ctrl[i]); end
            total++; if (obs_step[i] !== exp_step[i] || obs_run[i] !== 1'b1) begin bad++; $display("FAIL addi_step c%0d got=%0d/%b want=%0d/1", i, obs_step[i], obs_run[i], exp_step[i]); end
        end
        total++; if (dut_if.ctrl !== W_T0) begin bad++; $display("FAIL addi_next got=%h want=%h", dut_if.ctrl, W_T0); end
    endtask

    task automatic test_ld();
        int reads;
        dut_if.IR = I_LD;
        set_fetch();
        exp_ctrl[4] = GRB | BAOUT | YIN;   exp_step[4] = 4'd3;
        exp_ctrl[5] = COUT | ZIN;          exp_step[5] = 4'd4;
        exp_ctrl[6] = ZLOW | MARIN;        exp_step[6] = 4'd5;
        exp_ctrl[7] = READ | MDRIN;        exp_step[7] = 4'd6;
        exp_ctrl[8] = READ | MDRIN;        exp_step[8] = 4'd6;
        exp_ctrl[9] = MDROUT | GRA | RIN;  exp_step[9] = 4'd7;
        capture(10);
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i]) begin bad++; $display("FAIL ld_ctrl c%0d got=%h want=%h", i, obs_ctrl[i], exp_ctrl[i]); end
            total++; if (obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL ld_step c%0d got=%0d want=%0d", i, obs_step[i], exp_step[i]); end
            if (i >= 4 && obs_ctrl[i][6]) reads++;
        end
        total++; if (reads !== 2) begin bad++; $display("FAIL ld_read_cycles got=%0d want=2", reads); end
        total++; if (dut_if.ctrl !== W_T0) begin bad++; $display("FAIL ld_next got=%h want=%h", dut_if.ctrl, W_T0); end
    endtask

    task automatic test_st();
        int writes;
        dut_if.IR = I_ST;
        set_fetch();
        exp_ctrl[4] = GRB | BAOUT | YIN;   exp_step[4] = 4'd3;
        exp_ctrl[5] = COUT | ZIN;          exp_step[5] = 4'd4;
        exp_ctrl[6] = ZLOW | MARIN;        exp_step[6] = 4'd5;
        exp_ctrl[7] = GRA | ROUT | MDRIN;  exp_step[7] = 4'd6;
        exp_ctrl[8] = WRITE;               exp_step[8] = 4'd7;
        capture(9);
        writes = 0;
        for (int i = 0; i < 9; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i]) begin bad++; $display("FAIL st_ctrl c%0d got=%h want=%h", i, obs_ctrl[i], exp_ctrl[i]); end
            total++; if (obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL st_step c%0d got=%0d want=%0d", i, obs_step[i], exp_step[i]); end
            if (obs_ctrl[i][7]) writes++;
        end
        total++; if (writes !== 1) begin bad++; $display("FAIL st_write_cycles got=%0d want=1", writes); end
        total++; if (dut_if.ctrl !== W_T0) begin bad++; $display("FAIL st_next got=%h want=%h", dut_if.ctrl, W_T0); end
    endtask

    task automatic test_mul_jr_nop();
        // mul: 8 cycles
        dut_if.IR = I_MUL;
        set_fetch();
        exp_ctrl[4] = GRA | ROUT | YIN;  exp_step[4] = 4'd3;
        exp_ctrl[5] = GRB | ROUT | ZIN;  exp_step[5] = 4'd4;
        exp_ctrl[6] = ZLOW | LOIN;       exp_step[6] = 4'd5;
        exp_ctrl[7] = ZHIGH | HIIN;      exp_step[7] = 4'd6;
        capture(8);
        for (int i = 0; i < 8; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL mul c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
        end
        // jr: 5 cycles
        dut_if.IR = I_JR;
        set_fetch();
        exp_ctrl[4] = GRA | ROUT | PCIN; exp_step[4] = 4'd3;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL jr c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
        end
        // nop then an undefined opcode: 4 cycles each, straight back to T0
        dut_if.IR = I_NOP;
        set_fetch();
        capture(4);
        for (int i = 0; i < 4; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL nop c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
        end
        dut_if.IR = I_UNDF;
        capture(4);
        for (int i = 0; i < 4; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL undef c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
        end
        total++; if (dut_if.ctrl !== W_T0) begin bad++; $display("FAIL undef_next got=%h want=%h", dut_if.ctrl, W_T0); end
    endtask

    task automatic test_back_to_back();
        int hi_cnt;
        int lo_cnt;
        hi_cnt = 0;
        lo_cnt = 0;
        dut_if.IR = I_MFHI;
        set_fetch();
        exp_ctrl[4] = GRA | RIN | HIOUT; exp_step[4] = 4'd3;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL mfhi c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
            if (obs_ctrl[i][15]) hi_cnt++;
            if (obs_ctrl[i][16]) lo_cnt++;
        end
        dut_if.IR = I_MFLO;
        exp_ctrl[4] = GRA | RIN | LOOUT;
        capture(5);
        for (int i = 0; i < 5; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_step[i] !== exp_step[i]) begin bad++; $display("FAIL mflo c%0d got=%h/%0d want=%h/%0d", i, obs_ctrl[i], obs_step[i], exp_ctrl[i], exp_step[i]); end
            if (obs_ctrl[i][15]) hi_cnt++;
            if (obs_ctrl[i][16]) lo_cnt++;
        end
        total++; if (hi_cnt !== 1 || lo_cnt !== 1) begin bad++; $display("FAIL hilo_out_cycles got=%0d/%0d want=1/1", hi_cnt, lo_cnt); end
    endtask

    task automatic test_stop_t4();
        dut_if.IR = I_ADD;
        for (int i = 0; i < 5; i++) tick();
        total++; if (dut_if.busy_step !== 4'd4) begin bad++; $display("FAIL stop_t4_step got=%0d want=4", dut_if.busy_step); end
        dut_if.Stop = 1'b1;
        tick();
        dut_if.Stop = 1'b0;
        total++; if (dut_if.ctrl !== (ZLOW | GRA | RIN)) begin bad++; $display("FAIL stop_t5_ctrl got=%h want=%h", dut_if.ctrl, ZLOW | GRA | RIN); end
        tick();
        for (int i = 0; i < 20; i++) begin
            total++; if (dut_if.ctrl !== 24'h0 || dut_if.Run !== 1'b0 || dut_if.busy_step !== 4'd0) begin bad++; $display("FAIL halt_hold c%0d got=%h/%b/%0d want=000000/0/0", i, dut_if.ctrl, dut_if.Run, dut_if.busy_step); end
            tick();
        end
        apply_reset();
        total++; if (dut_if.ctrl !== W_T0 || dut_if.Run !== 1'b1) begin bad++; $display("FAIL halt_exit got=%h/%b want=%h/1", dut_if.ctrl, dut_if.Run, W_T0); end
    endtask

    task automatic test_stop_edges();
        // Stop in T0: the whole addi still executes.
        dut_if.IR = I_ADDI;
        dut_if.Stop = 1'b1;
        tick();
        dut_if.Stop = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++; if (dut_if.ctrl !== (ZLOW | GRA | RIN)) begin bad++; $display("FAIL stop_t0_t5 got=%h want=%h", dut_if.ctrl, ZLOW | GRA | RIN); end
        tick();
        total++; if (dut_if.Run !== 1'b0 || dut_if.ctrl !== 24'h0) begin bad++; $display("FAIL stop_t0_halt got=%b/%h want=0/000000", dut_if.Run, dut_if.ctrl); end
        apply_reset();
        // Stop raised only in the final step: no T0 is issued.
        for (int i = 0; i < 6; i++) tick();
        total++; if (dut_if.busy_step !== 4'd5) begin bad++; $display("FAIL stop_last_step got=%0d want=5", dut_if.busy_step); end
        dut_if.Stop = 1'b1;
        tick();
        dut_if.Stop = 1'b0;
        total++; if (dut_if.Run !== 1'b0 || dut_if.ctrl !== 24'h0) begin bad++; $display("FAIL stop_last_halt got=%b/%h want=0/000000", dut_if.Run, dut_if.ctrl); end
        apply_reset();
    endtask

    task automatic test_halt_op();
        dut_if.IR = I_HALT;
        for (int i = 0; i < 3; i++) tick();
        total++; if (dut_if.ctrl !== W_T2 || dut_if.busy_step !== 4'd2) begin bad++; $display("FAIL halt_t2 got=%h/%0d want=%h/2", dut_if.ctrl, dut_if.busy_step, W_T2); end
        tick();
        total++; if (dut_if.Run !== 1'b0 || dut_if.ctrl !== 24'h0) begin bad++; $display("FAIL halt_op got=%b/%h want=0/000000", dut_if.Run, dut_if.ctrl); end
        tick();
        total++; if (dut_if.Run !== 1'b0) begin bad++; $display("FAIL halt_op_hold got=%b want=0", dut_if.Run); end
        apply_reset();
    endtask

    task automatic test_reset_mid_ld();
        dut_if.IR = I_LD;
        for (int i = 0; i < 7; i++) tick();
        total++; if (dut_if.ctrl !== (READ | MDRIN) || dut_if.busy_step !== 4'd6) begin bad++; $display("FAIL abort_t6 got=%h/%0d want=%h/6", dut_if.ctrl, dut_if.busy_step, READ | MDRIN); end
        reset = 1'b1;
        tick();
        total++; if (dut_if.ctrl !== 24'h0 || dut_if.Run !== 1'b0 || dut_if.busy_step !== 4'd0) begin bad++; $display("FAIL abort_rst got=%h/%b/%0d want=000000/0/0", dut_if.ctrl, dut_if.Run, dut_if.busy_step); end
        reset = 1'b0;
        dut_if.IR = I_NOP;
        tick();
        set_fetch();
        capture(4);
        for (int i = 0; i < 4; i++) begin
            total++; if (obs_ctrl[i] !== exp_ctrl[i] || obs_run[i] !== 1'b1) begin bad++; $display("FAIL abort_refetch c%0d got=%h/%b want=%h/1", i, obs_ctrl[i], obs_run[i], exp_ctrl[i]); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        dut_if.Stop = 1'b0;
        dut_if.IR   = 32'h0;
        test_reset();
        test_addi();
        test_ld();
        test_st();
        test_mul_jr_nop();
        test_back_to_back();
        test_stop_t4();
        test_stop_edges();
        test_halt_op();
        test_reset_mid_ld();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
